wb_stage_q: RTL and testbench
=============================

WB_STAGE_Q -- requirements
Module: wb_stage_q

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning datapath/PC width.
REQ-002 SHALL have parameter RF_AW, default 5, meaning register-file address width.
REQ-003 SHALL have parameter DEPTH, default 2, meaning retire-queue entries (power of 2, >=2).
REQ-004 SHALL have parameter CSR_NUM_W, default 14, meaning CSR number width.
REQ-005 SHALL have ports, one per line:
- clk  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high.
- ms_valid  in  1  mem-stage entry valid.
- ws_allowin  out  1  queue accepts an entry this cycle.
- ms_pc  in  DATA_W  entry PC.
- ms_rf_we  in  1  entry writes RF.
- ms_rf_waddr  in  RF_AW  destination register.
- ms_rf_wdata  in  DATA_W  ALU/load result.
- ms_csr_re  in  1  result comes from CSR read.
- ms_csr_num  in  CSR_NUM_W  CSR index.
- ms_exc  in  8  {adem,ertn,ine,brk,sys,ale,adef,int}.
- csr_re  out  1  head requests CSR read.
- csr_num  out  CSR_NUM_W  head CSR index.
- csr_rvalue  in  DATA_W  CSR read data.
- csr_rready  in  1  csr_rvalue valid this cycle.
- rf_we  out  1  RF write strobe (retire).
- rf_waddr  out  RF_AW  RF write address.
- rf_wdata  out  DATA_W  RF write data.
- rf_wready  in  1  RF port granted this cycle.
- wb_ex  out  1  exception commit pulse.
- ertn_flush  out  1  ertn commit pulse.
- wb_pc  out  DATA_W  head PC.
- wb_ecode  out  6  exception code.
- wb_esubcode  out  9  exception subcode.
- ws_count  out  $clog2(DEPTH+1)  occupied entries.

Function
REQ-006 SHALL enqueue at the tail when ms_valid & ws_allowin; ws_allowin = (ws_count < DEPTH), from registered state only.
REQ-007 SHALL present the head entry no earlier than the cycle after enqueue; there is no bypass.
REQ-008 SHALL drive csr_re = head valid & head csr_re, with csr_num = head index.
REQ-009 Head retire condition: valid & no exception & (~csr_re | csr_rready) & (~rf_we | rf_wready); otherwise the head holds.
REQ-010 On retire, SHALL assert rf_we = head rf_we for one cycle, with rf_wdata = csr_re ? csr_rvalue : stored wdata.
REQ-011 Head with any ms_exc bit set SHALL commit in one cycle regardless of ready inputs, with no RF write.
REQ-012 Non-ertn exception SHALL pulse wb_ex; ertn-only SHALL pulse ertn_flush; when both apply, wb_ex wins and ertn_flush stays 0.
REQ-013 wb_ecode/esubcode SHALL use priority int 0x00 > adef 0x08/0 > adem 0x08/1 > ale 0x09 > sys 0x0B > brk 0x0C > ine 0x0D; both SHALL be 0 when wb_ex=0.
REQ-014 On wb_ex or ertn_flush, SHALL empty the queue next cycle (count=0, pointers equal) and drop any same-cycle enqueue.
REQ-015 Simultaneous enqueue and retire SHALL leave ws_count unchanged; enqueue when full is impossible (ws_allowin=0).
REQ-016 Pointers SHALL wrap modulo DEPTH.
REQ-017 wb_pc SHALL equal head PC when the queue is non-empty, else hold its last value.

Reset
REQ-018 When reset=1 at a clk edge: ws_count=0, pointers=0, wb_pc=0, and all strobes (rf_we, csr_re, wb_ex, ertn_flush) SHALL be 0 the following cycle, overriding any same-cycle enqueue or retire.
REQ-019 Queue payload contents SHALL need no reset.

Configuration
REQ-020 With WB_DEBUG_TRACE_EN defined, SHALL add outputs debug_wb_pc (DATA_W), debug_wb_rf_we (4, replicated rf_we), debug_wb_rf_wnum (RF_AW) and debug_wb_rf_wdata (DATA_W), mirroring each retire cycle; without the macro these ports and their logic SHALL be absent.

Verification
REQ-021 Enqueue rf_we=1, waddr=3, wdata=0x11, rf_wready=1 -> rf_we=1 next cycle, waddr=3, wdata=0x11; count 1->0.
REQ-022 DEPTH=2, rf_wready=0, three back-to-back valids -> ws_allowin=0 after 2 enqueues, count=2; third entry accepted only after rf_wready=1.
REQ-023 Head csr_re=1, csr_rvalue=0xABCD, csr_rready low 3 cycles then high -> rf_wdata=0xABCD on the ready cycle only.
REQ-024 Head ms_exc = sys|brk with an entry behind it -> wb_ex=1, ecode=0x0B, no rf_we; count=0 next cycle; same-cycle enqueue dropped.
REQ-025 Head ms_exc = ertn -> ertn_flush=1, wb_ex=0, ecode=0; queue emptied.
REQ-026 reset=1 with queue full -> count=0 and ws_allowin=1 next cycle; no rf_we.

Source files
------------

// File: rtl/wb_stage_q.sv
// wb_stage_q: write-back retire queue.
// Mem-stage entries enter at the tail and retire from the head. A head
// reading a CSR waits for csr_rready. A head writing the RF waits for
// rf_wready. A head carrying an exception commits at once and flushes the
// whole queue on the next cycle.
// Optional debug trace ports are enabled by defining WB_DEBUG_TRACE_EN.
module wb_stage_q #(
  parameter int DATA_W    = 32,
  parameter int RF_AW     = 5,
  parameter int DEPTH     = 2,
  parameter int CSR_NUM_W = 14
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         ms_valid,
  output logic                         ws_allowin,
  input  logic [DATA_W-1:0]            ms_pc,
  input  logic                         ms_rf_we,
  input  logic [RF_AW-1:0]             ms_rf_waddr,
  input  logic [DATA_W-1:0]            ms_rf_wdata,
  input  logic                         ms_csr_re,
  input  logic [CSR_NUM_W-1:0]         ms_csr_num,
  input  logic [7:0]                   ms_exc,
  output logic                         csr_re,
  output logic [CSR_NUM_W-1:0]         csr_num,
  input  logic [DATA_W-1:0]            csr_rvalue,
  input  logic                         csr_rready,
  output logic                         rf_we,
  output logic [RF_AW-1:0]             rf_waddr,
  output logic [DATA_W-1:0]            rf_wdata,
  input  logic                         rf_wready,
  output logic                         wb_ex,
  output logic                         ertn_flush,
  output logic [DATA_W-1:0]            wb_pc,
  output logic [5:0]                   wb_ecode,
  output logic [8:0]                   wb_esubcode,
  output logic [$clog2(DEPTH+1)-1:0]   ws_count
`ifdef WB_DEBUG_TRACE_EN
  ,
  output logic [DATA_W-1:0]            debug_wb_pc,
  output logic [3:0]                   debug_wb_rf_we,
  output logic [RF_AW-1:0]             debug_wb_rf_wnum,
  output logic [DATA_W-1:0]            debug_wb_rf_wdata
`endif
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int PW = $clog2(DEPTH);

  // Exception vector bit {adem,ertn,ine,brk,sys,ale,adef,int}; ertn is bit 6.
  localparam logic [7:0] NON_ERTN_MASK = 8'hBF;

  // Priority encoder: returns {ecode[5:0], esubcode[8:0]}.
  function automatic logic [14:0] exc_code(input logic [7:0] e);
    logic [14:0] r;
    if (e[0])      r = {6'h00, 9'd0};   // int
    else if (e[1]) r = {6'h08, 9'd0};   // adef
    else if (e[7]) r = {6'h08, 9'd1};   // adem
    else if (e[2]) r = {6'h09, 9'd0};   // ale
    else if (e[3]) r = {6'h0B, 9'd0};   // sys
    else if (e[4]) r = {6'h0C, 9'd0};   // brk
    else if (e[5]) r = {6'h0D, 9'd0};   // ine
    else           r = {6'h00, 9'd0};
    return r;
  endfunction

  // Queue payload storage. It has no reset, because validity comes only
  // from the count.
  logic [DATA_W-1:0]    pc_q    [DEPTH];
  logic                 rfwe_q  [DEPTH];
  logic [RF_AW-1:0]     waddr_q [DEPTH];
  logic [DATA_W-1:0]    wdata_q [DEPTH];
  logic                 csrre_q [DEPTH];
  logic [CSR_NUM_W-1:0] csrnum_q[DEPTH];
  logic [7:0]           exc_q   [DEPTH];

  logic [CW-1:0]     count_r;
  logic [PW-1:0]     wr_ptr_r;
  logic [PW-1:0]     rd_ptr_r;
  logic [DATA_W-1:0] last_pc_r;

  logic        head_valid_s;
  logic [7:0]  head_exc_s;
  logic        exc_any_s;
  logic        ex_s;
  logic        retire_s;
  logic        enq_s;
  logic [14:0] code_s;

  assign head_valid_s = (count_r != CW'(0));
  assign head_exc_s   = exc_q[rd_ptr_r];
  assign exc_any_s    = head_valid_s & (head_exc_s != 8'h00);
  assign ex_s         = head_valid_s & ((head_exc_s & NON_ERTN_MASK) != 8'h00);
  assign retire_s     = head_valid_s & ~exc_any_s
                      & (~csrre_q[rd_ptr_r] | csr_rready)
                      & (~rfwe_q[rd_ptr_r] | rf_wready);
  assign ws_allowin   = (count_r < CW'(DEPTH));
  assign enq_s        = ms_valid & ws_allowin & ~exc_any_s;

  assign csr_re     = head_valid_s & csrre_q[rd_ptr_r];
  assign csr_num    = csrnum_q[rd_ptr_r];
  assign rf_we      = retire_s & rfwe_q[rd_ptr_r];
  assign rf_waddr   = waddr_q[rd_ptr_r];
  assign rf_wdata   = csrre_q[rd_ptr_r] ? csr_rvalue : wdata_q[rd_ptr_r];
  assign wb_ex      = ex_s;
  assign ertn_flush = exc_any_s & ~ex_s;
  assign wb_pc      = head_valid_s ? pc_q[rd_ptr_r] : last_pc_r;
  assign ws_count   = count_r;

  // Exception codes, forced to zero unless an exception is committing.
  always_comb begin
    code_s = 15'd0;
    if (ex_s) begin
      code_s = exc_code(head_exc_s);
    end else begin
      code_s = 15'd0;
    end
  end

  assign wb_ecode    = code_s[14:9];
  assign wb_esubcode = code_s[8:0];

  // Occupancy and pointer control. A flush clears the queue and discards
  // any enqueue in the same cycle.
  always_ff @(posedge clk) begin
    if (reset || exc_any_s) begin
      count_r  <= CW'(0);
      wr_ptr_r <= PW'(0);
      rd_ptr_r <= PW'(0);
    end else begin
      if (enq_s)    wr_ptr_r <= wr_ptr_r + PW'(1);
      if (retire_s) rd_ptr_r <= rd_ptr_r + PW'(1);
      case ({enq_s, retire_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Tail write of the incoming mem-stage entry.
  always_ff @(posedge clk) begin
    if (enq_s && !reset) begin
      pc_q[wr_ptr_r]     <= ms_pc;
      rfwe_q[wr_ptr_r]   <= ms_rf_we;
      waddr_q[wr_ptr_r]  <= ms_rf_waddr;
      wdata_q[wr_ptr_r]  <= ms_rf_wdata;
      csrre_q[wr_ptr_r]  <= ms_csr_re;
      csrnum_q[wr_ptr_r] <= ms_csr_num;
      exc_q[wr_ptr_r]    <= ms_exc;
    end
  end

  // Remember the most recent head PC so that wb_pc holds it while the queue is empty.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_pc_r <= {DATA_W{1'b0}};
    end else if (head_valid_s) begin
      last_pc_r <= pc_q[rd_ptr_r];
    end
  end

`ifdef WB_DEBUG_TRACE_EN
  assign debug_wb_pc       = wb_pc;
  assign debug_wb_rf_we    = {4{rf_we}};
  assign debug_wb_rf_wnum  = rf_waddr;
  assign debug_wb_rf_wdata = rf_wdata;
`endif

endmodule

// File: tb/tb_wb_stage_q.sv
// tb_wb_stage_q: randomized and directed stimulus for wb_stage_q, checked
// against a queue-based reference model.
module tb_wb_stage_q;
  localparam int DATA_W = 32;
  localparam int RF_AW = 5;
  localparam int DEPTH = 2;
  localparam int CSR_NUM_W = 14;

  logic clk = 1'b0;
  logic reset, ms_valid, ms_rf_we, ms_csr_re, csr_rready, rf_wready;
  logic [DATA_W-1:0] ms_pc, ms_rf_wdata, csr_rvalue;
  logic [RF_AW-1:0] ms_rf_waddr;
  logic [CSR_NUM_W-1:0] ms_csr_num;
  logic [7:0] ms_exc;
  logic ws_allowin, csr_re, rf_we, wb_ex, ertn_flush;
  logic [CSR_NUM_W-1:0] csr_num;
  logic [RF_AW-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata, wb_pc;
  logic [5:0] wb_ecode;
  logic [8:0] wb_esubcode;
  logic [$clog2(DEPTH+1)-1:0] ws_count;

  wb_stage_q #(.DATA_W(DATA_W), .RF_AW(RF_AW), .DEPTH(DEPTH), .CSR_NUM_W(CSR_NUM_W)) dut (
    .clk(clk), .reset(reset), .ms_valid(ms_valid), .ws_allowin(ws_allowin),
    .ms_pc(ms_pc), .ms_rf_we(ms_rf_we), .ms_rf_waddr(ms_rf_waddr),
    .ms_rf_wdata(ms_rf_wdata), .ms_csr_re(ms_csr_re), .ms_csr_num(ms_csr_num),
    .ms_exc(ms_exc), .csr_re(csr_re), .csr_num(csr_num), .csr_rvalue(csr_rvalue),
    .csr_rready(csr_rready), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .rf_wready(rf_wready), .wb_ex(wb_ex), .ertn_flush(ertn_flush), .wb_pc(wb_pc),
    .wb_ecode(wb_ecode), .wb_esubcode(wb_esubcode), .ws_count(ws_count)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic        rf_we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        csr_re;
    logic [13:0] csr_num;
    logic [7:0]  exc;
  } entry_t;

  entry_t q[$];
  logic [31:0] last_pc = 32'h0;
  int checks = 0;
  int errors = 0;

  // Exception priority order (bit index) and code per position.
  int          prio_bit[7] = '{0, 1, 7, 2, 3, 4, 5};
  logic [5:0]  prio_code[7] = '{6'h00, 6'h08, 6'h08, 6'h09, 6'h0B, 6'h0C, 6'h0D};
  logic [8:0]  prio_sub[7] = '{9'd0, 9'd0, 9'd1, 9'd0, 9'd0, 9'd0, 9'd0};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One cycle: settle, compare against the model, step the model over the edge.
  task automatic cycle();
    bit has, exc_any, is_ex, is_ertn, do_retire, do_enq;
    logic [5:0] ec;
    logic [8:0] es;
    entry_t h;
    entry_t n;
    #1;
    has = (q.size() > 0);
    if (has) h = q[0];
    exc_any = has && (h.exc != 8'h00);
    is_ex = 1'b0;
    ec = 6'h00; es = 9'd0;
    if (exc_any) begin
      for (int i = 0; i < 7; i++) begin
        if (!is_ex && h.exc[prio_bit[i]]) begin
          is_ex = 1'b1; ec = prio_code[i]; es = prio_sub[i];
        end
      end
    end
    is_ertn = exc_any && !is_ex;
    do_retire = has && !exc_any && (!h.csr_re || csr_rready) && (!h.rf_we || rf_wready);
    do_enq = ms_valid && (q.size() < DEPTH);

    chk("allowin", ws_allowin, q.size() < DEPTH);
    chk("count", ws_count, q.size());
    chk("csr_re", csr_re, has && h.csr_re);
    if (has && h.csr_re) chk("csr_num", csr_num, h.csr_num);
    chk("rf_we", rf_we, do_retire && h.rf_we);
    if (do_retire && h.rf_we) begin
      chk("rf_waddr", rf_waddr, h.waddr);
      chk("rf_wdata", rf_wdata, h.csr_re ? csr_rvalue : h.wdata);
    end
    chk("wb_ex", wb_ex, is_ex);
    chk("ertn_flush", ertn_flush, is_ertn);
    chk("ecode", wb_ecode, ec);
    chk("esubcode", wb_esubcode, es);
    chk("wb_pc", wb_pc, has ? h.pc : last_pc);

    @(posedge clk);
    if (reset) begin
      q.delete();
      last_pc = 32'h0;
    end else begin
      if (has) last_pc = h.pc;
      if (exc_any) begin
        q.delete();
      end else begin
        if (do_retire) void'(q.pop_front());
        if (do_enq) begin
          n.pc = ms_pc; n.rf_we = ms_rf_we; n.waddr = ms_rf_waddr; n.wdata = ms_rf_wdata;
          n.csr_re = ms_csr_re; n.csr_num = ms_csr_num; n.exc = ms_exc;
          q.push_back(n);
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic rand_inputs();
    reset = ($urandom_range(0, 99) == 0);
    ms_valid = $urandom_range(0, 1);
    ms_pc = $urandom;
    ms_rf_we = ($urandom_range(0, 3) != 0);
    ms_rf_waddr = RF_AW'($urandom);
    ms_rf_wdata = $urandom;
    ms_csr_re = ($urandom_range(0, 3) == 0);
    ms_csr_num = CSR_NUM_W'($urandom);
    case ($urandom_range(0, 11))
      0: ms_exc = 8'($urandom);
      1: ms_exc = 8'h40;
      2: ms_exc = 8'h01 << $urandom_range(0, 7);
      default: ms_exc = 8'h00;
    endcase
    csr_rvalue = $urandom;
    csr_rready = $urandom_range(0, 1);
    rf_wready = $urandom_range(0, 1);
  endtask

  task automatic idle_inputs();
    reset = 1'b0; ms_valid = 1'b0; ms_pc = 32'h0; ms_rf_we = 1'b0;
    ms_rf_waddr = 5'd0; ms_rf_wdata = 32'h0; ms_csr_re = 1'b0; ms_csr_num = 14'd0;
    ms_exc = 8'h00; csr_rvalue = 32'h0; csr_rready = 1'b0; rf_wready = 1'b0;
  endtask

  task automatic enq_entry(input logic [31:0] pc, input logic we, input logic [4:0] wa,
                           input logic [31:0] wd, input logic cre, input logic [7:0] exc);
    ms_valid = 1'b1; ms_pc = pc; ms_rf_we = we; ms_rf_waddr = wa; ms_rf_wdata = wd;
    ms_csr_re = cre; ms_csr_num = 14'h0123; ms_exc = exc;
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cycle();
    reset = 1'b0;
    cycle();

    // Single RF write retires the cycle after enqueue.
    rf_wready = 1'b1;
    enq_entry(32'h100, 1'b1, 5'd3, 32'h11, 1'b0, 8'h00);
    cycle();
    ms_valid = 1'b0;
    cycle();
    cycle();

    // Back-pressure fills the queue; the third entry waits for rf_wready.
    rf_wready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      enq_entry(32'h200 + 32'(i * 4), 1'b1, 5'(i + 1), 32'h50 + 32'(i), 1'b0, 8'h00);
      cycle();
    end
    rf_wready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      enq_entry(32'h300 + 32'(i * 4), 1'b1, 5'd9, 32'h77, 1'b0, 8'h00);
      cycle();
    end
    ms_valid = 1'b0;
    for (int i = 0; i < 3; i++) cycle();

    // CSR read stalls until csr_rready.
    csr_rvalue = 32'hABCD;
    enq_entry(32'h400, 1'b1, 5'd7, 32'h0, 1'b1, 8'h00);
    cycle();
    ms_valid = 1'b0;
    csr_rready = 1'b0;
    for (int i = 0; i < 3; i++) cycle();
    csr_rready = 1'b1;
    cycle();
    cycle();
    csr_rready = 1'b0;

    // Exceptions: sys|brk, ertn only, and ertn+sys, each with an enqueue in the same cycle.
    for (int k = 0; k < 3; k++) begin
      logic [7:0] ev;
      ev = (k == 0) ? 8'h18 : ((k == 1) ? 8'h40 : 8'h48);
      rf_wready = 1'b0;
      enq_entry(32'h500, 1'b1, 5'd2, 32'h22, 1'b0, 8'h00);
      cycle();
      enq_entry(32'h504, 1'b1, 5'd4, 32'h44, 1'b0, ev);
      cycle();
      rf_wready = 1'b1;
      ms_valid = 1'b0;
      cycle();
      enq_entry(32'h508, 1'b1, 5'd5, 32'h55, 1'b0, 8'h00);
      cycle();
      ms_valid = 1'b0;
      cycle();
      cycle();
    end

    // Reset while full, with an enqueue and a retire-ready in the same cycle.
    rf_wready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      enq_entry(32'h600 + 32'(i), 1'b1, 5'd6, 32'h66, 1'b0, 8'h00);
      cycle();
    end
    reset = 1'b1;
    rf_wready = 1'b1;
    cycle();
    reset = 1'b0;
    ms_valid = 1'b0;
    cycle();

    for (int i = 0; i < 3000; i++) begin
      rand_inputs();
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
